alu_secuenciador: RTL and testbench
===================================

// Module: alu_secuenciador
// PURPOSE
//  Multi-cycle controller that sequences the 8-bit ALU of the Micro UAZ core.
//  Owns a small register bank whose entry 0 is the accumulator R0. Accepts one command (opcode + RX select),
//  presents the operands, pulses the ALU enable and waits for the result to settle.
//  Writes the result back to R0 and latches the flags. Sits between the decode logic and the combinational ALU.
// PARAMETERS
//  ANCHO          8  datapath width in bits
//  NUM_REGS       4  register bank depth; entry 0 = R0; power of 2, >=2
//  ESPERA_CICLOS  1  settle cycles after the enable pulse; legal range 1..7
// PORTS
//  Reloj        in   1                  clock, rising edge
//  nReset       in   1                  asynchronous reset, active low
//  Inicio       in   1                  command strobe; sampled only in REPOSO
//  Codigo       in   3                  ALU opcode: 000 add, 001 sub, 010 shl, 011 shr, 100 not, 101 and, 110 or, 111 xor
//  SelRX        in   $clog2(NUM_REGS)   bank index of the RX operand
//  CargaEn      in   1                  bank write strobe from the loader
//  CargaSel     in   $clog2(NUM_REGS)   bank write index
//  CargaDato    in   ANCHO              bank write data
//  Operacion    out  4                  to ALU: [3] enable, [2:0] opcode
//  OpR0         out  ANCHO              to ALU R0 operand
//  OpRX         out  ANCHO              to ALU RX operand
//  Resultado    in   ANCHO              from ALU
//  Banderas     in   3                  from ALU: [0] zero, [1] carry, [2] sign
//  BanderasReg  out  3                  flags latched at write-back
//  Acumulador   out  ANCHO              current R0 contents
//  Ocupado      out  1                  high in every state except REPOSO
//  Listo        out  1                  one-cycle completion pulse
// BEHAVIOUR
//  - Reset (nReset=0, async): state=REPOSO; all bank entries, OpR0, OpRX, Operacion, BanderasReg = 0.
//    Ocupado=0, Listo=0. Reset aborts any in-flight command; no write-back occurs.
//  - States:
//    - REPOSO: Inicio=1 latches Codigo and SelRX, goes to CARGA.
//    - CARGA: OpR0<=bank[0], OpRX<=bank[SelRX], goes to EJECUTA.
//    - EJECUTA: Operacion[3]=1 for exactly this one cycle, goes to ESPERA.
//    - ESPERA: stays ESPERA_CICLOS cycles (3-bit counter), then goes to ESCRIBE.
//    - ESCRIBE: bank[0]<=Resultado, BanderasReg<=Banderas, Listo<=1, goes to REPOSO.
//  - Operacion[2:0] holds the latched opcode from CARGA until the next accept. It reads 0 only after reset.
//  - OpR0 and OpRX are stable from CARGA exit until ESCRIBE exit.
//  - Latency: Inicio sampled at edge n -> Listo=1 and R0 updated after edge n+3+ESPERA_CICLOS (4 edges by default).
//    Listo is high for one cycle only, in REPOSO.
//  - Back-to-back: Inicio high in the Listo cycle is accepted. The new CARGA reads the just-written R0.
//  - Inicio while Ocupado=1 is ignored, not queued.
//  - CargaEn is honoured only in REPOSO; it is ignored while Ocupado=1.
//    CargaEn and Inicio in the same REPOSO cycle: both act. CARGA sees the newly loaded value.
//  - SelRX=0 uses R0 as both operands. Opcode 100 (not) ignores R0 but still writes R0.
//  - Results are truncated to ANCHO bits, and the carry flag comes solely from Banderas[1].
// CONFIGURATION
//  SEC_DESTINO_RX_EN defined:
//    - Adds input DestRX (1 bit), latched with Inicio.
//    - DestRX=1 makes ESCRIBE write bank[SelRX] instead of bank[0]. Flags are still latched.
//    - DestRX=1 with SelRX=0 is equivalent to DestRX=0.
//  SEC_DESTINO_RX_EN undefined:
//    - No DestRX port; write-back always goes to R0.
// TESTING
//  1 Reset mid-EJECUTA (R0=0x10 preloaded, add issued) -> all outputs 0, R0=0x00, no Listo, next Inicio accepted normally.
//  2 Load R0=0x35, R1=0x12; Inicio Codigo=000 SelRX=1 -> Operacion=4'b1000 for exactly one cycle.
//    After 4 edges: Listo=1 for one cycle, Acumulador=0x47, BanderasReg=3'b000.
//  3 R0=0x05, R2=0x05, sub SelRX=2 -> Acumulador=0x00, BanderasReg[0]=1.
//    Then back-to-back xor SelRX=0 in the Listo cycle -> Acumulador=0x00, 4 edges later.
//  4 Inicio pulsed and CargaEn (sel 1, 0xFF) issued while Ocupado=1 -> both ignored.
//    Only one Listo; R1 keeps its value.
//  5 ESPERA_CICLOS=3: R0=0x01, R3=0x03, shl SelRX=3 -> Listo exactly 6 edges after accept; Acumulador=0x08.
//  6 SEC_DESTINO_RX_EN: R0=0xF0, R1=0x0F, or SelRX=1 DestRX=1 -> R1=0xFF, R0 stays 0xF0, BanderasReg[2]=1.

Source files
------------

// File: rtl/alu_secuenciador_if.sv
// Command, loader, ALU and status bundle of the Micro UAZ ALU sequencer.
// DestRX_i exists only when SEC_DESTINO_RX_EN is defined.
interface alu_secuenciador_if #(
    parameter int ANCHO    = 8,
    parameter int NUM_REGS = 4
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic             Inicio_i;
    logic [2:0]       Codigo_i;
    logic [SEL_W-1:0] SelRX_i;
`ifdef SEC_DESTINO_RX_EN
    logic             DestRX_i;
`endif
    logic             CargaEn_i;
    logic [SEL_W-1:0] CargaSel_i;
    logic [ANCHO-1:0] CargaDato_i;
    logic [3:0]       Operacion_o;
    logic [ANCHO-1:0] OpR0_o;
    logic [ANCHO-1:0] OpRX_o;
    logic [ANCHO-1:0] Resultado_i;
    logic [2:0]       Banderas_i;
    logic [2:0]       BanderasReg_o;
    logic [ANCHO-1:0] Acumulador_o;
    logic             Ocupado_o;
    logic             Listo_o;

    modport slave (
`ifdef SEC_DESTINO_RX_EN
        input  DestRX_i,
`endif
        input  Inicio_i, Codigo_i, SelRX_i,
        input  CargaEn_i, CargaSel_i, CargaDato_i,
        input  Resultado_i, Banderas_i,
        output Operacion_o, OpR0_o, OpRX_o,
        output BanderasReg_o, Acumulador_o, Ocupado_o, Listo_o
    );

    modport master (
`ifdef SEC_DESTINO_RX_EN
        output DestRX_i,
`endif
        output Inicio_i, Codigo_i, SelRX_i,
        output CargaEn_i, CargaSel_i, CargaDato_i,
        output Resultado_i, Banderas_i,
        input  Operacion_o, OpR0_o, OpRX_o,
        input  BanderasReg_o, Acumulador_o, Ocupado_o, Listo_o
    );
endinterface

// File: rtl/alu_secuenciador.sv
// Multi-cycle sequencer for the Micro UAZ 8-bit ALU: operand fetch, enable pulse, settle, R0 write-back.
// Optional SEC_DESTINO_RX_EN: DestRX_i redirects the write-back to bank[SelRX].
//
// state   | meaning
// REPOSO  | idle; accepts Inicio and loader writes
// CARGA   | copy R0 and bank[SelRX] into the operand registers
// EJECUTA | ALU enable high for this single cycle
// ESPERA  | result settle time, ESPERA_CICLOS cycles
// ESCRIBE | write result and flags back, raise Listo for the next cycle
module alu_secuenciador #(
    parameter int ANCHO         = 8,
    parameter int NUM_REGS      = 4,
    parameter int ESPERA_CICLOS = 1
) (
    input logic                Reloj_i,
    input logic                nReset_i,
    alu_secuenciador_if.slave  bus
);
    localparam int         SEL_W      = $clog2(NUM_REGS);
    localparam logic [2:0] CUENTA_INI = 3'(ESPERA_CICLOS - 1);

    typedef enum logic [2:0] {REPOSO, CARGA, EJECUTA, ESPERA, ESCRIBE} estado_t;

    estado_t          estado_q, estado_d;
    logic [2:0]       cuenta_q, cuenta_d;
    logic [2:0]       codigo_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] destino;
    logic [ANCHO-1:0] banco_q [NUM_REGS];
    logic [ANCHO-1:0] op_r0_q, op_rx_q;
    logic [2:0]       banderas_q;
    logic             listo_q;
    logic             acepta;

    assign acepta = (estado_q == REPOSO) && bus.Inicio_i;

    always_comb begin
        estado_d = estado_q;
        cuenta_d = cuenta_q;
        case (estado_q)
            REPOSO:  if (bus.Inicio_i) estado_d = CARGA;
            CARGA:   estado_d = EJECUTA;
            EJECUTA: begin
                estado_d = ESPERA;
                cuenta_d = CUENTA_INI;
            end
            ESPERA: begin
                if (cuenta_q == 3'd0) estado_d = ESCRIBE;
                else                  cuenta_d = cuenta_q - 3'd1;
            end
            ESCRIBE: estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
    end

`ifdef SEC_DESTINO_RX_EN
    logic dest_q;

    always_ff @(posedge Reloj_i or negedge nReset_i) begin
        if (!nReset_i)   dest_q <= 1'b0;
        else if (acepta) dest_q <= bus.DestRX_i;
    end

    // SelRX = 0 with DestRX set lands on R0 anyway
    assign destino = dest_q ? sel_q : '0;
`else
    assign destino = '0;
`endif

    always_ff @(posedge Reloj_i or negedge nReset_i) begin
        if (!nReset_i) begin
            estado_q   <= REPOSO;
            cuenta_q   <= 3'd0;
            codigo_q   <= 3'd0;
            sel_q      <= '0;
            op_r0_q    <= '0;
            op_rx_q    <= '0;
            banderas_q <= 3'd0;
            listo_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) banco_q[i] <= '0;
        end else begin
            estado_q <= estado_d;
            cuenta_q <= cuenta_d;
            listo_q  <= (estado_q == ESCRIBE);
            if (acepta) begin
                codigo_q <= bus.Codigo_i;
                sel_q    <= bus.SelRX_i;
            end
            if ((estado_q == REPOSO) && bus.CargaEn_i)
                banco_q[bus.CargaSel_i] <= bus.CargaDato_i;
            if (estado_q == CARGA) begin
                op_r0_q <= banco_q[0];
                op_rx_q <= banco_q[sel_q];
            end
            if (estado_q == ESCRIBE) begin
                banco_q[destino] <= bus.Resultado_i;
                banderas_q       <= bus.Banderas_i;
            end
        end
    end

    assign bus.Operacion_o   = {(estado_q == EJECUTA), codigo_q};
    assign bus.OpR0_o        = op_r0_q;
    assign bus.OpRX_o        = op_rx_q;
    assign bus.BanderasReg_o = banderas_q;
    assign bus.Acumulador_o  = banco_q[0];
    assign bus.Ocupado_o     = (estado_q != REPOSO);
    assign bus.Listo_o       = listo_q;
endmodule

// File: tb/tb_alu_secuenciador.sv
// Scoreboard bench for alu_secuenciador: default settle time plus a second instance with ESPERA_CICLOS=3.
module tb_alu_secuenciador;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ciclo = 0;
    int   checks = 0;
    int   failures = 0;
    int   pulsos = 0;
    int   pulsos_esp = 0;
    bit   en_prev = 1'b0;

    typedef struct {
        logic [7:0] acc;
        logic [2:0] fl;
        int         ciclo;
    } exp_t;

    exp_t q_m[$];
    exp_t q_3[$];
    exp_t mon_e;
    exp_t mon3_e;

    always #5 clk = ~clk;
    always @(posedge clk) ciclo <= ciclo + 1;

    alu_secuenciador_if #(.ANCHO(8), .NUM_REGS(4)) bus_m ();
    alu_secuenciador_if #(.ANCHO(8), .NUM_REGS(4)) bus_3 ();

    alu_secuenciador #(.ANCHO(8), .NUM_REGS(4), .ESPERA_CICLOS(1)) u_dut (
        .Reloj_i(clk), .nReset_i(rst_n), .bus(bus_m));
    alu_secuenciador #(.ANCHO(8), .NUM_REGS(4), .ESPERA_CICLOS(3)) u_dut3 (
        .Reloj_i(clk), .nReset_i(rst_n), .bus(bus_3));

    // Reference ALU: returns {sign, carry, zero, result}
    function automatic logic [10:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        logic       c;
        t = 9'd0;
        case (op)
            3'd0: t = {1'b0, a} + {1'b0, b};
            3'd1: t = {1'b0, a} - {1'b0, b};
            3'd2: t = {1'b0, a << b};
            3'd3: t = {1'b0, a >> b};
            3'd4: t = {1'b0, ~b};
            3'd5: t = {1'b0, a & b};
            3'd6: t = {1'b0, a | b};
            default: t = {1'b0, a ^ b};
        endcase
        c = (op == 3'd0 || op == 3'd1) ? t[8] : 1'b0;
        return {t[7], c, (t[7:0] == 8'd0), t[7:0]};
    endfunction

    assign {bus_m.Banderas_i, bus_m.Resultado_i} = alu_f(bus_m.Operacion_o[2:0], bus_m.OpR0_o, bus_m.OpRX_o);
    assign {bus_3.Banderas_i, bus_3.Resultado_i} = alu_f(bus_3.Operacion_o[2:0], bus_3.OpR0_o, bus_3.OpRX_o);

    task automatic chk(input string nombre, input int act, input int esp);
        checks++;
        if (act != esp) begin
            failures++;
            $display("FAIL %s: obtenido=0x%0h esperado=0x%0h (ciclo %0d)", nombre, act, esp, ciclo);
        end
    endtask

    always @(negedge clk) begin
        if (bus_m.Operacion_o[3]) begin
            pulsos++;
            chk("en_un_solo_ciclo", int'(en_prev), 0);
        end
        en_prev = bus_m.Operacion_o[3];
        if (bus_m.Listo_o) begin
            if (q_m.size() == 0) begin
                chk("listo_inesperado", 1, 0);
            end else begin
                mon_e = q_m.pop_front();
                chk("acumulador", bus_m.Acumulador_o, mon_e.acc);
                chk("banderas", bus_m.BanderasReg_o, mon_e.fl);
                chk("latencia", ciclo, mon_e.ciclo);
            end
        end
    end

    always @(negedge clk) begin
        if (bus_3.Listo_o) begin
            if (q_3.size() == 0) begin
                chk("listo3_inesperado", 1, 0);
            end else begin
                mon3_e = q_3.pop_front();
                chk("acumulador3", bus_3.Acumulador_o, mon3_e.acc);
                chk("banderas3", bus_3.BanderasReg_o, mon3_e.fl);
                chk("latencia3", ciclo, mon3_e.ciclo);
            end
        end
    end

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    task automatic cargar(input logic [1:0] sel, input logic [7:0] dato);
        bus_m.CargaEn_i   = 1'b1;
        bus_m.CargaSel_i  = sel;
        bus_m.CargaDato_i = dato;
        paso();
        bus_m.CargaEn_i   = 1'b0;
    endtask

    task automatic emitir(input bit push, input logic [2:0] cod, input logic [1:0] sel, input bit dest,
                          input bit ld, input logic [1:0] ld_sel, input logic [7:0] ld_dat,
                          input logic [7:0] acc, input logic [2:0] fl);
        exp_t e;
        bus_m.Inicio_i    = 1'b1;
        bus_m.Codigo_i    = cod;
        bus_m.SelRX_i     = sel;
`ifdef SEC_DESTINO_RX_EN
        bus_m.DestRX_i    = dest;
`endif
        bus_m.CargaEn_i   = ld;
        bus_m.CargaSel_i  = ld_sel;
        bus_m.CargaDato_i = ld_dat;
        if (push) begin
            e.acc   = acc;
            e.fl    = fl;
            e.ciclo = ciclo + 5;
            q_m.push_back(e);
            pulsos_esp++;
        end
        paso();
        bus_m.Inicio_i  = 1'b0;
        bus_m.CargaEn_i = 1'b0;
`ifdef SEC_DESTINO_RX_EN
        bus_m.DestRX_i  = 1'b0;
`endif
    endtask

    task automatic esperar_reposo();
        for (int i = 0; i < 40 && (bus_m.Ocupado_o || bus_m.Listo_o); i++) paso();
        if (bus_m.Ocupado_o || bus_m.Listo_o) chk("timeout_reposo", 1, 0);
    endtask

    task automatic esperar_listo();
        for (int i = 0; i < 40 && !bus_m.Listo_o; i++) paso();
        if (!bus_m.Listo_o) chk("timeout_listo", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout_global: obtenido=sin_fin esperado=fin");
        $fatal(1, "global time limit");
    end

    initial begin
        exp_t e3;
        bus_m.Inicio_i = 1'b0; bus_m.Codigo_i = 3'd0; bus_m.SelRX_i = 2'd0;
        bus_m.CargaEn_i = 1'b0; bus_m.CargaSel_i = 2'd0; bus_m.CargaDato_i = 8'd0;
        bus_3.Inicio_i = 1'b0; bus_3.Codigo_i = 3'd0; bus_3.SelRX_i = 2'd0;
        bus_3.CargaEn_i = 1'b0; bus_3.CargaSel_i = 2'd0; bus_3.CargaDato_i = 8'd0;
`ifdef SEC_DESTINO_RX_EN
        bus_m.DestRX_i = 1'b0;
        bus_3.DestRX_i = 1'b0;
`endif
        paso(); paso();
        chk("rst_operacion", bus_m.Operacion_o, 0);
        chk("rst_acumulador", bus_m.Acumulador_o, 0);
        chk("rst_banderas", bus_m.BanderasReg_o, 0);
        chk("rst_ocupado", bus_m.Ocupado_o, 0);
        chk("rst_listo", bus_m.Listo_o, 0);
        rst_n = 1'b1;
        paso();

        // Reset in the middle of EJECUTA aborts the command
        cargar(2'd0, 8'h10);
        cargar(2'd1, 8'h01);
        emitir(0, 3'd0, 2'd1, 0, 0, 2'd0, 8'h00, 8'h00, 3'b000);
        paso();
        chk("op_ejecuta", bus_m.Operacion_o, 4'b1000);
        rst_n = 1'b0;
        #1;
        chk("abort_operacion", bus_m.Operacion_o, 0);
        chk("abort_opr0", bus_m.OpR0_o, 0);
        chk("abort_oprx", bus_m.OpRX_o, 0);
        chk("abort_acumulador", bus_m.Acumulador_o, 0);
        chk("abort_ocupado", bus_m.Ocupado_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        paso();
        emitir(1, 3'd0, 2'd0, 0, 0, 2'd0, 8'h00, 8'h00, 3'b001);
        esperar_reposo();

        // add, then sub to zero followed back-to-back by xor R0,R0
        cargar(2'd0, 8'h35);
        cargar(2'd1, 8'h12);
        emitir(1, 3'd0, 2'd1, 0, 0, 2'd0, 8'h00, 8'h47, 3'b000);
        esperar_reposo();
        cargar(2'd0, 8'h05);
        cargar(2'd2, 8'h05);
        emitir(1, 3'd1, 2'd2, 0, 0, 2'd0, 8'h00, 8'h00, 3'b001);
        esperar_listo();
        emitir(1, 3'd7, 2'd0, 0, 0, 2'd0, 8'h00, 8'h00, 3'b001);
        esperar_reposo();
        chk("opcode_retenido", bus_m.Operacion_o, 4'b0111);

        // back-to-back chain must see the freshly written R0
        cargar(2'd0, 8'h20);
        emitir(1, 3'd0, 2'd1, 0, 0, 2'd0, 8'h00, 8'h32, 3'b000);
        esperar_listo();
        emitir(1, 3'd0, 2'd1, 0, 0, 2'd0, 8'h00, 8'h44, 3'b000);
        esperar_reposo();

        // Inicio and CargaEn while busy are dropped
        emitir(1, 3'd0, 2'd1, 0, 0, 2'd0, 8'h00, 8'h56, 3'b000);
        bus_m.Inicio_i = 1'b1; bus_m.Codigo_i = 3'd7; bus_m.SelRX_i = 2'd2;
        bus_m.CargaEn_i = 1'b1; bus_m.CargaSel_i = 2'd1; bus_m.CargaDato_i = 8'hFF;
        paso(); paso();
        bus_m.Inicio_i = 1'b0; bus_m.CargaEn_i = 1'b0;
        esperar_reposo();
        cargar(2'd0, 8'h00);
        emitir(1, 3'd6, 2'd1, 0, 0, 2'd0, 8'h00, 8'h12, 3'b000);
        esperar_reposo();

        // Load and Inicio in the same idle cycle: CARGA sees the new R2
        emitir(1, 3'd6, 2'd2, 0, 1, 2'd2, 8'h0F, 8'h1F, 3'b000);
        esperar_reposo();

        // remaining opcodes, carry and borrow
        cargar(2'd0, 8'h81);
        cargar(2'd3, 8'h01);
        emitir(1, 3'd3, 2'd3, 0, 0, 2'd0, 8'h00, 8'h40, 3'b000);
        esperar_reposo();
        cargar(2'd0, 8'hFF);
        cargar(2'd1, 8'h02);
        emitir(1, 3'd0, 2'd1, 0, 0, 2'd0, 8'h00, 8'h01, 3'b010);
        esperar_reposo();
        emitir(1, 3'd1, 2'd1, 0, 0, 2'd0, 8'h00, 8'hFF, 3'b110);
        esperar_reposo();
        cargar(2'd3, 8'h0F);
        emitir(1, 3'd4, 2'd3, 0, 0, 2'd0, 8'h00, 8'hF0, 3'b100);
        esperar_reposo();
        emitir(1, 3'd5, 2'd3, 0, 0, 2'd0, 8'h00, 8'h00, 3'b001);
        esperar_reposo();

`ifdef SEC_DESTINO_RX_EN
        cargar(2'd0, 8'hF0);
        cargar(2'd1, 8'h0F);
        emitir(1, 3'd6, 2'd1, 1, 0, 2'd0, 8'h00, 8'hF0, 3'b100);
        esperar_reposo();
        cargar(2'd0, 8'h00);
        emitir(1, 3'd6, 2'd1, 0, 0, 2'd0, 8'h00, 8'hFF, 3'b100);
        esperar_reposo();
        cargar(2'd0, 8'h03);
        emitir(1, 3'd0, 2'd0, 1, 0, 2'd0, 8'h00, 8'h06, 3'b000);
        esperar_reposo();
`endif

        // Three settle cycles: Listo six edges after accept
        bus_3.CargaEn_i = 1'b1; bus_3.CargaSel_i = 2'd0; bus_3.CargaDato_i = 8'h01;
        paso();
        bus_3.CargaSel_i = 2'd3; bus_3.CargaDato_i = 8'h03;
        paso();
        bus_3.CargaEn_i = 1'b0;
        bus_3.Inicio_i = 1'b1; bus_3.Codigo_i = 3'd2; bus_3.SelRX_i = 2'd3;
        e3.acc = 8'h08; e3.fl = 3'b000; e3.ciclo = ciclo + 7;
        q_3.push_back(e3);
        paso();
        bus_3.Inicio_i = 1'b0;
        for (int i = 0; i < 40 && (bus_3.Ocupado_o || bus_3.Listo_o); i++) paso();
        if (bus_3.Ocupado_o || bus_3.Listo_o) chk("timeout_reposo3", 1, 0);

        paso(); paso();
        chk("pulsos_en", pulsos, pulsos_esp);
        chk("cola_pendiente", q_m.size(), 0);
        chk("cola3_pendiente", q_3.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
